// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target block.
// Holds the transfer state enumeration, the RX FIFO depth and the default idle byte
// shifted out when no TX byte has been loaded.
package spi_target_pkg;

  typedef enum logic {
    StIdle,
    StActive
  } state_e;

  localparam int unsigned RxFifoDepth = 4;

  localparam logic [7:0] TxIdleByteDefault = 8'hFF;

endpackage

// File: rtl/spi_target_if.sv
// Host-side handshake bundle of the SPI target.
//   tx_data/tx_strobe/tx_busy          : TX holding register load handshake
//   rx_data/rx_ready/rx_ready_clear    : RX storage read handshake
//   rx_overrun/tx_underrun/flags_clear : sticky error flags and their clear
// Modports: master = host side, slave = SPI target side.
interface spi_target_if;

  logic [7:0] tx_data;
  logic       tx_strobe;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_ready_clear;
  logic       rx_overrun;
  logic       tx_underrun;
  logic       flags_clear;

  modport master (
    output tx_data, tx_strobe, rx_ready_clear, flags_clear,
    input  tx_busy, rx_data, rx_ready, rx_overrun, tx_underrun
  );

  modport slave (
    input  tx_data, tx_strobe, rx_ready_clear, flags_clear,
    output tx_busy, rx_data, rx_ready, rx_overrun, tx_underrun
  );

endinterface

// File: rtl/spi_target_rx_fifo.sv
// RX byte storage of the SPI target.
// Build option SPI_TARGET_RX_FIFO_EN: when defined, storage is a 4-entry FIFO; otherwise a
// single holding register.
// Ports:
//   raw_clk, reset_n : system clock, asynchronous active-low reset
//   push, push_data  : write a received byte
//   pop              : consume the head byte (ignored when empty)
//   head_data        : oldest stored byte
//   not_empty        : at least one byte stored
//   drop             : pulse, a pushed byte was discarded because storage was full
module spi_target_rx_fifo
  import spi_target_pkg::*;
(
  input  logic       raw_clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head_data,
  output logic       not_empty,
  output logic       drop
);

`ifdef SPI_TARGET_RX_FIFO_EN

  localparam int unsigned PtrW = $clog2(RxFifoDepth);

  logic [7:0]      mem_q [RxFifoDepth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            full, pop_ok, push_ok;

  assign full    = (count_q == (PtrW + 1)'(RxFifoDepth));
  assign pop_ok  = pop & (count_q != '0);
  // A same-cycle pop frees the slot the push needs, so the push is accepted.
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < RxFifoDepth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign not_empty = (count_q != '0);

`else

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       pop_ok, push_ok;

  assign pop_ok  = pop & valid_q;
  assign push_ok = push & (~valid_q | pop_ok);
  assign drop    = push & ~push_ok;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (pop_ok) begin
      valid_d = 1'b0;
    end
    if (push_ok) begin
      data_d  = push_data;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign head_data = data_q;
  assign not_empty = valid_q;

`endif

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with a host-side byte interface.
// sclk, cs_n and mosi are oversampled by raw_clk through SYNC_STAGES-deep synchronizers
// (legal 2..3); sclk must be at most raw_clk/8.
// Build option SPI_TARGET_RX_FIFO_EN selects a 4-entry RX FIFO instead of a single register.
// Ports:
//   raw_clk, reset_n     : system clock, asynchronous active-low reset
//   sclk, cs_n, mosi     : SPI inputs from the initiator
//   miso, miso_oe        : SPI data out and its pad output enable
//   host                 : TX/RX byte handshake and sticky flags (spi_target_if.slave)
module spi_target
  import spi_target_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [7:0]  TX_IDLE_BYTE = TxIdleByteDefault
) (
  input  logic         raw_clk,
  input  logic         reset_n,
  input  logic         sclk,
  input  logic         cs_n,
  input  logic         mosi,
  output logic         miso,
  output logic         miso_oe,
  spi_target_if.slave  host
);

  // Synchronizers and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   started_q, armed_q, armed_d;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      started_q   <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      started_q   <= 1'b1;
      armed_q     <= armed_d;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // The synchronizer preset makes cs_n look high after reset. Only arm the falling-edge
  // detector once a genuinely sampled high has entered the chain, so a cs_n held low across
  // reset release is not mistaken for a fresh frame start.
  assign armed_d = armed_q | (started_q & cs_sync_q[0]);

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q & armed_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  assign miso_oe = ~cs_s;

  // Frame FSM
  state_e state_q, state_d;
  logic   enter_active, abort, bit_rise, bit_fall;

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cs_fall) state_d = StActive;
      StActive: if (cs_rise) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    enter_active = 1'b0;
    abort        = 1'b0;
    bit_rise     = 1'b0;
    bit_fall     = 1'b0;
    unique case (state_q)
      StIdle: enter_active = cs_fall;
      StActive: begin
        if (cs_rise) begin
          abort = 1'b1;
        end else begin
          bit_rise = sclk_rise;
          bit_fall = sclk_fall;
        end
      end
      default: ;
    endcase
  end

  // Shift datapath and host-side registers
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] hold_q, hold_d;
  logic       busy_q, busy_d;
  logic       reload_q, reload_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic       overrun_q, overrun_d;
  logic       underrun_q, underrun_d;
  logic       tx_load, underrun_set, accept;
  logic       push, drop;
  logic [7:0] push_data;

  // Holding-to-shift transfer: at frame start, or on the first falling edge after a byte wraps.
  assign tx_load   = enter_active | (bit_fall & reload_q);
  assign push_data = {rx_shift_q, mosi_s};
  // The transfer empties the holding register, so a same-cycle strobe lands in it.
  assign accept    = host.tx_strobe & (~busy_q | tx_load);

  always_comb begin
    tx_shift_d   = tx_shift_q;
    hold_d       = hold_q;
    busy_d       = busy_q;
    reload_d     = reload_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    underrun_set = 1'b0;
    push         = 1'b0;

    if (tx_load) begin
      tx_shift_d   = busy_q ? hold_q : TX_IDLE_BYTE;
      underrun_set = ~busy_q;
      busy_d       = 1'b0;
      reload_d     = 1'b0;
    end else if (bit_fall) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end

    if (bit_rise) begin
      rx_shift_d = push_data[6:0];
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        push     = 1'b1;
        reload_d = 1'b1;
      end
    end

    if (abort || enter_active) begin
      bit_cnt_d  = '0;
      rx_shift_d = '0;
      reload_d   = 1'b0;
    end

    if (accept) begin
      hold_d = host.tx_data;
      busy_d = 1'b1;
    end
  end

  // A set in the same cycle as a clear wins.
  assign overrun_d  = (host.flags_clear ? 1'b0 : overrun_q) | drop;
  assign underrun_d = (host.flags_clear ? 1'b0 : underrun_q) | underrun_set;

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift_q <= '0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      reload_q   <= 1'b0;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      tx_shift_q <= tx_shift_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      reload_q   <= reload_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  spi_target_rx_fifo u_rx_fifo (
    .raw_clk   (raw_clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (host.rx_ready_clear),
    .head_data (host.rx_data),
    .not_empty (host.rx_ready),
    .drop      (drop)
  );

  assign miso             = tx_shift_q[7];
  assign host.tx_busy     = busy_q;
  assign host.rx_overrun  = overrun_q;
  assign host.tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: an SPI mode-0 initiator model plus host-side pulses, with
// hand-computed expectations checked by immediate assertions.
module tb_spi_target;

  localparam int H    = 8;  // raw_clk cycles per sclk half period
  localparam int SYNC = 2;

  logic raw_clk;
  logic reset_n;
  logic sclk, cs_n, mosi;
  logic miso, miso_oe;

  int n_cmp  = 0;
  int n_fail = 0;

  spi_target_if host_if ();

  spi_target #(
    .SYNC_STAGES  (SYNC),
    .TX_IDLE_BYTE (8'hFF)
  ) dut (
    .raw_clk (raw_clk),
    .reset_n (reset_n),
    .sclk    (sclk),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .miso    (miso),
    .miso_oe (miso_oe),
    .host    (host_if.slave)
  );

  initial begin
    raw_clk = 1'b0;
    forever #5 raw_clk = ~raw_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge raw_clk);
  endtask

  // One mode-0 bit; miso is sampled just before the rising edge. With clr set, rx_ready_clear
  // is pulsed in the cycle the target pushes the byte completed by this rising edge.
  task automatic spi_bit(input logic b, input logic clr, output logic mo);
    mosi = b;
    tick(H);
    mo   = miso;
    sclk = 1'b1;
    if (clr) begin
      tick(SYNC);
      host_if.rx_ready_clear = 1'b1;
      tick(1);
      host_if.rx_ready_clear = 1'b0;
      tick(H - SYNC - 1);
    end else begin
      tick(H);
    end
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input logic clr_last, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], clr_last && (i == 0), b);
      rx[i] = b;
    end
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    tick(H);
  endtask

  task automatic frame_end();
    tick(H);
    cs_n = 1'b1;
    tick(H);
  endtask

  task automatic tx_strobe(input logic [7:0] d);
    host_if.tx_data   = d;
    host_if.tx_strobe = 1'b1;
    tick(1);
    host_if.tx_strobe = 1'b0;
    tick(1);
  endtask

  task automatic rx_pop();
    host_if.rx_ready_clear = 1'b1;
    tick(1);
    host_if.rx_ready_clear = 1'b0;
    tick(1);
  endtask

  task automatic clear_flags();
    host_if.flags_clear = 1'b1;
    tick(1);
    host_if.flags_clear = 1'b0;
    tick(1);
  endtask

  initial begin
    logic [7:0] mo;
    logic       b;

    reset_n = 1'b1;
    sclk    = 1'b0;
    cs_n    = 1'b1;
    mosi    = 1'b0;
    host_if.tx_data        = '0;
    host_if.tx_strobe      = 1'b0;
    host_if.rx_ready_clear = 1'b0;
    host_if.flags_clear    = 1'b0;

    // Reset applies with no clock edge yet
    #1 reset_n = 1'b0;
    #1;
    check1("rst_miso", miso, 1'b0);
    check1("rst_miso_oe", miso_oe, 1'b0);
    check1("rst_tx_busy", host_if.tx_busy, 1'b0);
    check1("rst_rx_ready", host_if.rx_ready, 1'b0);
    check8("rst_rx_data", host_if.rx_data, 8'h00);
    check1("rst_rx_overrun", host_if.rx_overrun, 1'b0);
    check1("rst_tx_underrun", host_if.tx_underrun, 1'b0);
    tick(3);
    reset_n = 1'b1;
    tick(4);

    // rx_ready_clear with nothing stored
    rx_pop();
    check1("empty_pop_ready", host_if.rx_ready, 1'b0);
    check1("empty_pop_overrun", host_if.rx_overrun, 1'b0);

    // A5 out / 3C in; second strobe while busy must be ignored
    tx_strobe(8'hA5);
    check1("tx_busy_after_load", host_if.tx_busy, 1'b1);
    tx_strobe(8'h42);
    frame_start();
    check1("miso_oe_active", miso_oe, 1'b1);
    spi_byte(8'h3C, 1'b0, mo);
    frame_end();
    check8("miso_a5", mo, 8'hA5);
    check1("rx_ready_3c", host_if.rx_ready, 1'b1);
    check8("rx_data_3c", host_if.rx_data, 8'h3C);
    check1("tx_busy_after_frame", host_if.tx_busy, 1'b0);
    check1("miso_oe_idle", miso_oe, 1'b0);
    rx_pop();
    check1("rx_ready_popped", host_if.rx_ready, 1'b0);

    // Two bytes with nothing loaded
    clear_flags();
    check1("underrun_cleared_0", host_if.tx_underrun, 1'b0);
    frame_start();
    spi_byte(8'h01, 1'b0, mo);
    check8("miso_idle_0", mo, 8'hFF);
    check8("rx_data_01", host_if.rx_data, 8'h01);
    rx_pop();
    spi_byte(8'h02, 1'b0, mo);
    check8("miso_idle_1", mo, 8'hFF);
    frame_end();
    check1("underrun_set", host_if.tx_underrun, 1'b1);
    check8("rx_data_02", host_if.rx_data, 8'h02);
    rx_pop();
    clear_flags();
    check1("underrun_cleared_1", host_if.tx_underrun, 1'b0);

    // Five bytes, no pops
    frame_start();
    for (int k = 1; k <= 5; k++) begin
      spi_byte(8'(k * 8'h11), 1'b0, mo);
    end
    frame_end();
    check1("overrun_set", host_if.rx_overrun, 1'b1);
`ifdef SPI_TARGET_RX_FIFO_EN
    for (int k = 1; k <= 4; k++) begin
      check8("fifo_pop_order", host_if.rx_data, 8'(k * 8'h11));
      rx_pop();
    end
    check1("fifo_empty", host_if.rx_ready, 1'b0);
`else
    check8("reg_keeps_first", host_if.rx_data, 8'h11);
    check1("reg_ready", host_if.rx_ready, 1'b1);
    rx_pop();
    check1("reg_empty", host_if.rx_ready, 1'b0);
`endif
    clear_flags();
    check1("overrun_cleared", host_if.rx_overrun, 1'b0);

    // Push into full storage with a same-cycle pop
    frame_start();
`ifdef SPI_TARGET_RX_FIFO_EN
    for (int k = 1; k <= 4; k++) begin
      spi_byte(8'(8'h60 + k), 1'b0, mo);
    end
`else
    spi_byte(8'h66, 1'b0, mo);
`endif
    spi_byte(8'h99, 1'b1, mo);
    frame_end();
    check1("same_cycle_no_overrun", host_if.rx_overrun, 1'b0);
`ifdef SPI_TARGET_RX_FIFO_EN
    for (int k = 2; k <= 4; k++) begin
      check8("same_cycle_fifo_order", host_if.rx_data, 8'(8'h60 + k));
      rx_pop();
    end
`endif
    check8("same_cycle_kept", host_if.rx_data, 8'h99);
    check1("same_cycle_ready", host_if.rx_ready, 1'b1);
    rx_pop();
    check1("same_cycle_drained", host_if.rx_ready, 1'b0);

    // Abort after 5 bits, then a clean 7E
    frame_start();
    for (int i = 0; i < 5; i++) begin
      spi_bit(i[0], 1'b0, b);
    end
    frame_end();
    check1("abort_no_push", host_if.rx_ready, 1'b0);
    frame_start();
    spi_byte(8'h7E, 1'b0, mo);
    frame_end();
    check1("after_abort_ready", host_if.rx_ready, 1'b1);
    check8("after_abort_data", host_if.rx_data, 8'h7E);
    rx_pop();
    check1("after_abort_single", host_if.rx_ready, 1'b0);

    // Reset mid-transfer after 3 bits
    tx_strobe(8'h5A);
    frame_start();
    tx_strobe(8'h77);
    check1("busy_before_reset", host_if.tx_busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      spi_bit(1'b1, 1'b0, b);
    end
    reset_n = 1'b0;
    #1;
    check1("mid_rst_tx_busy", host_if.tx_busy, 1'b0);
    check1("mid_rst_miso_oe", miso_oe, 1'b0);
    check1("mid_rst_miso", miso, 1'b0);
    check1("mid_rst_rx_ready", host_if.rx_ready, 1'b0);
    check8("mid_rst_rx_data", host_if.rx_data, 8'h00);
    check1("mid_rst_underrun", host_if.tx_underrun, 1'b0);
    check1("mid_rst_overrun", host_if.rx_overrun, 1'b0);
    tick(1);
    cs_n = 1'b1;
    tick(4);
    reset_n = 1'b1;
    tick(H);
    frame_start();
    spi_byte(8'hC3, 1'b0, mo);
    frame_end();
    check8("post_rst_miso", mo, 8'hFF);
    check1("post_rst_ready", host_if.rx_ready, 1'b1);
    check8("post_rst_data", host_if.rx_data, 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on sclk, cs_n and mosi (legal 2..3).
REQ-002 SHALL have parameter TX_IDLE_BYTE, default 8'hFF, giving the byte shifted out when no TX byte is loaded.
REQ-003 raw_clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 sclk  input  1  SPI clock from external initiator, mode 0 (CPOL=0, CPHA=0).
REQ-006 cs_n  input  1  active-low chip select.
REQ-007 mosi  input  1  serial data in, MSB first.
REQ-008 miso  output  1  serial data out, MSB first.
REQ-009 miso_oe  output  1  high while the synchronized cs_n is low; drives the pad tri-state.
REQ-010 tx_data  input  8  byte to send.
REQ-011 tx_strobe  input  1  load tx_data; accepted only when tx_busy=0.
REQ-012 tx_busy  output  1  TX holding register full.
REQ-013 rx_data  output  8  oldest received byte.
REQ-014 rx_ready  output  1  at least one received byte available.
REQ-015 rx_ready_clear  input  1  one-cycle pulse; consumes rx_data.
REQ-016 rx_overrun  output  1  sticky flag; a received byte was dropped.
REQ-017 tx_underrun  output  1  sticky flag; a byte started with the holding register empty.
REQ-018 flags_clear  input  1  clears rx_overrun and tx_underrun.

Function
REQ-019 Edge detection SHALL run on the synchronized sclk and cs_n only; sclk SHALL be at most raw_clk/8.
REQ-020 State machine SHALL have two states:
- IDLE to ACTIVE on synchronized cs_n falling.
- ACTIVE to IDLE on cs_n rising.
REQ-021 On entering ACTIVE, the shift register SHALL load the holding register and clear tx_busy; if the holding register is empty, it SHALL load TX_IDLE_BYTE and set tx_underrun.
REQ-022 A sclk rising edge SHALL sample mosi into the RX shift register; a sclk falling edge SHALL advance miso to the next bit.
REQ-023 The 3-bit bit counter SHALL increment on each rising edge and wrap 7 to 0.
REQ-024 Actions on wrap:
- the completed byte SHALL be pushed to RX;
- on the next falling edge the TX shift register SHALL reload from the holding register, with the REQ-021 rules.
REQ-025 rx_ready SHALL assert exactly one raw_clk after the internal detection of the 8th rising edge.
REQ-026 If RX is full at push time, the new byte SHALL be dropped and rx_overrun set.
- Exception: if rx_ready_clear arrives in the same cycle as the push, the pop SHALL happen first and no overrun occurs.
REQ-027 tx_strobe while tx_busy=1 SHALL be ignored; the holding register is unchanged.
REQ-028 tx_strobe in the same cycle as a holding-to-shift transfer SHALL load the new byte and leave tx_busy=1.
REQ-029 cs_n rising mid-byte SHALL:
- discard the partial RX byte without a push;
- zero the bit counter;
- leave the holding register and RX contents intact.
REQ-030 rx_ready_clear while rx_ready=0 SHALL have no effect.
REQ-031 flags_clear and a same-cycle flag set SHALL leave the flag set.

Reset
REQ-032 While reset_n=0, the following SHALL reset:
- state=IDLE;
- miso=0, miso_oe=0, tx_busy=0, rx_ready=0, rx_data=0;
- rx_overrun=0, tx_underrun=0;
- RX storage emptied;
- synchronizers preset to sclk=0, cs_n=1.
REQ-033 Reset SHALL apply and release without requiring raw_clk activity.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer; after release the block SHALL wait for a fresh cs_n falling edge.

Configuration
REQ-035 With SPI_TARGET_RX_FIFO_EN defined, RX storage SHALL be a 4-entry FIFO:
- rx_data shows the head entry;
- full = 4 entries;
- pointers wrap modulo 4.
REQ-036 Without SPI_TARGET_RX_FIFO_EN, RX storage SHALL be a single holding register; full = rx_ready.

Structure
REQ-037 A shared package SHALL hold the state enumeration, FIFO depth constant 4, and the default TX_IDLE_BYTE.
REQ-038 One sub-module, spi_target_rx_fifo, SHALL implement RX storage in both configurations.

Verification
REQ-039 Load tx_data=8'hA5 and send 8'h3C: miso carries 10100101; rx_data=8'h3C with rx_ready=1; tx_busy=0.
REQ-040 Send 2 bytes with no TX loaded: miso carries 8'hFF twice and tx_underrun=1; after flags_clear, tx_underrun=0.
REQ-041 Send 8'h11,22,33,44,55 with no clears:
- FIFO build: rx_overrun=1; pops return 11,22,33,44.
- Single-register build: rx_overrun=1; rx_data=8'h11.
REQ-042 Raise cs_n after 5 bits, then send 8'h7E: exactly one rx_ready; rx_data=8'h7E.
REQ-043 Pulse reset_n low after bit 3: all outputs take their REQ-032 values; the next full byte 8'hC3 is received correctly.
REQ-044 Drive rx_ready_clear in the same cycle as a push into full storage: no overrun; the new byte is retained.
